// File: rtl/reg_bus_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_sequencer_pkg
// Shared definitions for the register-bus sequencer:
//   - instruction mode codes (instr[7:6])
//   - ALU op codes and branch condition codes (instr[2:0])
//   - FSM state encoding
//   - fixed register slot indices used by the implicit-operand modes
//   - slot_sel(): slot index -> one-hot enable vector
// -----------------------------------------------------------------------------
package reg_bus_sequencer_pkg;

   typedef enum logic [1:0] {
      MODE_IMM  = 2'b00,
      MODE_CALC = 2'b01,
      MODE_COPY = 2'b10,
      MODE_COND = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ALU_OR   = 3'd0,
      ALU_NAND = 3'd1,
      ALU_NOR  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_ADD  = 3'd4,
      ALU_SUB  = 3'd5,
      ALU_XOR  = 3'd6,
      ALU_XNOR = 3'd7
   } alu_op_e;

   // Conditions evaluate an 8-bit two's-complement value.
   typedef enum logic [2:0] {
      COND_NEVER  = 3'd0,
      COND_EQZ    = 3'd1,
      COND_LTZ    = 3'd2,
      COND_LEZ    = 3'd3,
      COND_ALWAYS = 3'd4,
      COND_NEZ    = 3'd5,
      COND_GEZ    = 3'd6,
      COND_GTZ    = 3'd7
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_BRANCH = 2'd3
   } state_e;

   // Slot 0 doubles as IMM destination and branch target source.
   localparam logic [2:0] SLOT_IMM = 3'd0;
   localparam logic [2:0] SLOT_OP1 = 3'd1;
   localparam logic [2:0] SLOT_OP2 = 3'd2;
   localparam logic [2:0] SLOT_RES = 3'd3;

   function automatic logic [7:0] slot_sel(input logic [2:0] idx);
      return 8'(1) << idx;
   endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// reg_bus_sequencer_if
// Instruction handshake plus register-file bus of the sequencer.
//   instr_valid/instr/instr_ready : instruction handshake
//   load1_en/load2_en             : one-hot read enables for bus1/bus2
//   bus1/bus2                     : shared read buses from the register file
//   save_en/save_byte             : one-hot write enable and write data
//   pc_load/pc_target             : jump request and address
//   done                          : one-cycle completion pulse
// modport master : sequencer view
// modport slave  : instruction source / register file view
// -----------------------------------------------------------------------------
interface reg_bus_sequencer_if;

   logic       instr_valid;
   logic [7:0] instr;
   logic       instr_ready;
   logic [7:0] load1_en;
   logic [7:0] load2_en;
   logic [7:0] save_en;
   logic [7:0] bus1;
   logic [7:0] bus2;
   logic [7:0] save_byte;
   logic       pc_load;
   logic [7:0] pc_target;
   logic       done;

   modport master (
      input  instr_valid, instr, bus1, bus2,
      output instr_ready, load1_en, load2_en, save_en, save_byte,
             pc_load, pc_target, done
   );

   modport slave (
      output instr_valid, instr, bus1, bus2,
      input  instr_ready, load1_en, load2_en, save_en, save_byte,
             pc_load, pc_target, done
   );

endinterface

// File: rtl/reg_bus_sequencer_alu8_cond.sv
// -----------------------------------------------------------------------------
// alu8_cond
// Combinational 8-bit ALU and branch-condition evaluator.
//   a, b      : operands (a is port-1, b is port-2)
//   op        : ALU operation
//   result    : 8-bit result, ADD/SUB wrap modulo 256
//   cond      : condition code applied to a as a signed value
//   cond_true : condition outcome
// -----------------------------------------------------------------------------
module alu8_cond
   import reg_bus_sequencer_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  alu_op_e    op,
   input  cond_e      cond,
   output logic [7:0] result,
   output logic       cond_true
);

   logic is_zero;
   logic is_neg;

   always_comb begin
      result = '0;
      case (op)
         ALU_OR:   result = a | b;
         ALU_NAND: result = ~(a & b);
         ALU_NOR:  result = ~(a | b);
         ALU_AND:  result = a & b;
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_XOR:  result = a ^ b;
         ALU_XNOR: result = ~(a ^ b);
         default:  result = '0;
      endcase
   end

   assign is_zero = (a == '0);
   assign is_neg  = a[7];

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         COND_NEVER:  cond_true = 1'b0;
         COND_EQZ:    cond_true = is_zero;
         COND_LTZ:    cond_true = is_neg;
         COND_LEZ:    cond_true = is_neg | is_zero;
         COND_ALWAYS: cond_true = 1'b1;
         COND_NEZ:    cond_true = ~is_zero;
         COND_GEZ:    cond_true = ~is_neg;
         COND_GTZ:    cond_true = ~is_neg & ~is_zero;
         default:     cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/reg_bus_sequencer.sv
// -----------------------------------------------------------------------------
// reg_bus_sequencer
// Executes one 8-bit instruction at a time against an external 8-slot register
// file reached through two shared read buses and a one-hot write enable.
//   clk : rising-edge clock
//   res : synchronous active-high reset
//   bus : reg_bus_sequencer_if.master (handshake, enables, buses, jump, done)
// Flow: IDLE -accept-> WRITE (IMM) or READ -> WRITE (CALC/COPY) / BRANCH (COND)
//       -> IDLE. Bus outputs are decoded only from registered state, latched
//       instruction and captured operands.
// -----------------------------------------------------------------------------
module reg_bus_sequencer
   import reg_bus_sequencer_pkg::*;
(
   input  logic                      clk,
   input  logic                      res,
   reg_bus_sequencer_if.master       bus
);

   state_e     state_q,     state_d;
   logic [7:0] instr_q,     instr_d;
   logic [7:0] op1_q,       op1_d;
   logic [7:0] op2_q,       op2_d;
   logic [7:0] pc_target_q, pc_target_d;

   mode_e      mode_q;
   logic [2:0] field_a_q;
   logic [2:0] field_b_q;
   logic [7:0] alu_result;
   logic       cond_true;

   assign mode_q    = mode_e'(instr_q[7:6]);
   assign field_a_q = instr_q[5:3];
   assign field_b_q = instr_q[2:0];

   // Op and condition share the low field; the mode decides which is used.
   alu8_cond u_alu8_cond (
      .a         (op1_q),
      .b         (op2_q),
      .op        (alu_op_e'(instr_q[2:0])),
      .cond      (cond_e'(instr_q[2:0])),
      .result    (alu_result),
      .cond_true (cond_true)
   );

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      pc_target_d = pc_target_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.instr_valid) begin
               instr_d = bus.instr;
               state_d = (mode_e'(bus.instr[7:6]) == MODE_IMM) ? ST_WRITE : ST_READ;
            end
         end
         ST_READ: begin
            op1_d   = bus.bus1;
            op2_d   = bus.bus2;
            state_d = (mode_q == MODE_COND) ? ST_BRANCH : ST_WRITE;
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         ST_BRANCH: begin
            pc_target_d = op2_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q     <= ST_IDLE;
         instr_q     <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         pc_target_q <= '0;
      end else begin
         state_q     <= state_d;
         instr_q     <= instr_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         pc_target_q <= pc_target_d;
      end
   end

   // Output decode
   always_comb begin
      bus.instr_ready = (state_q == ST_IDLE);
      bus.load1_en    = '0;
      bus.load2_en    = '0;
      bus.save_en     = '0;
      bus.save_byte   = '0;
      bus.pc_load     = 1'b0;
      bus.done        = 1'b0;
      // pc_target shows the live operand during BRANCH, then holds it.
      bus.pc_target   = pc_target_q;
      case (state_q)
         ST_READ: begin
            case (mode_q)
               MODE_CALC: begin
                  bus.load1_en = slot_sel(SLOT_OP1);
                  bus.load2_en = slot_sel(SLOT_OP2);
               end
               MODE_COPY: begin
                  bus.load1_en = slot_sel(field_a_q);
               end
               MODE_COND: begin
                  bus.load1_en = slot_sel(SLOT_RES);
                  bus.load2_en = slot_sel(SLOT_IMM);
               end
               default: ;
            endcase
         end
         ST_WRITE: begin
            bus.done = 1'b1;
            case (mode_q)
               MODE_IMM: begin
                  bus.save_en   = slot_sel(SLOT_IMM);
                  bus.save_byte = {2'b00, instr_q[5:0]};
               end
               MODE_CALC: begin
                  bus.save_en   = slot_sel(SLOT_RES);
                  bus.save_byte = alu_result;
               end
               MODE_COPY: begin
                  bus.save_en   = slot_sel(field_b_q);
                  bus.save_byte = op1_q;
               end
               default: ;
            endcase
         end
         ST_BRANCH: begin
            bus.done      = 1'b1;
            bus.pc_load   = cond_true;
            bus.pc_target = op2_q;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/reg_bus_sequencer.md
REG_BUS_SEQUENCER -- requirements
Module: reg_bus_sequencer

Interface
REQ-001 The block SHALL have ports clk (in, 1, rising-edge clock) and res (in, 1, synchronous active-high reset): one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these further ports:
- instr_valid (in, 1): instruction offered.
- instr (in, 8): [7:6] mode, [5:3] field A, [2:0] field B.
- instr_ready (out, 1): sequencer accepts an instruction this cycle.
- load1_en (out, 8): one-hot read-port-1 enables, one per register slot 0-7.
- load2_en (out, 8): one-hot read-port-2 enables.
- save_en (out, 8): one-hot write enables.
- bus1 (in, 8): shared port-1 tri-state bus.
- bus2 (in, 8): shared port-2 tri-state bus.
- save_byte (out, 8): write data.
- pc_load (out, 1): jump pulse.
- pc_target (out, 8): jump address.
- done (out, 1): one-cycle completion pulse.

Function
REQ-003 Mode codes SHALL be:
- 00 IMM: write {2'b00, instr[5:0]} to slot 0.
- 01 CALC: slot1 op slot2 -> slot3, with op = instr[2:0].
- 10 COPY: slot A -> slot B.
- 11 COND: test slot 3 with cond = instr[2:0]; if true, jump to the value of slot 0.
REQ-004 The FSM states SHALL be IDLE, READ, WRITE and BRANCH.
REQ-005 instr_ready SHALL be 1 only in IDLE.
REQ-006 An instruction SHALL be accepted on the edge where instr_valid and instr_ready are both 1, and instr SHALL be latched on that edge.
REQ-007 On acceptance, IMM SHALL go to WRITE and all other modes SHALL go to READ.
REQ-008 In READ the block SHALL assert the source enables as follows:
- CALC: load1_en bit 1 and load2_en bit 2.
- COPY: load1_en bit A.
- COND: load1_en bit 3 and load2_en bit 0.
REQ-009 In READ, bus1 and bus2 SHALL be captured into operand registers at the end of the cycle, and the next state SHALL be WRITE (CALC, COPY) or BRANCH (COND).
REQ-010 In WRITE the block SHALL assert exactly one save_en bit (0 for IMM, 3 for CALC, B for COPY) and drive save_byte with the result; the next state SHALL be IDLE and done SHALL pulse in that same cycle.
REQ-011 In BRANCH, pc_load SHALL equal the condition result, pc_target SHALL equal the captured port-2 operand, done SHALL pulse, and the next state SHALL be IDLE.
REQ-012 Latency SHALL be as follows, with acceptance at edge N:
- IMM: WRITE in cycle N+1, ready again in N+2.
- All other modes: READ in N+1, WRITE/BRANCH in N+2, ready again in N+3.
REQ-013 Outside their active states, all enables, pc_load and done SHALL be 0; save_byte SHALL be 0 outside WRITE; pc_target SHALL hold its last value.
REQ-014 ALU ops SHALL be 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (port1 minus port2), 6 XOR, 7 XNOR; all results SHALL be 8 bits and ADD/SUB SHALL wrap modulo 256 with carry discarded.
REQ-015 Conditions on the signed 8-bit value SHALL be 0 never, 1 =0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
REQ-016 COPY with A equal to B SHALL be legal: read and write the same slot, value unchanged.
REQ-017 At most one bit SHALL be set in each of load1_en, load2_en and save_en at any time, and save_en SHALL never be asserted in the same cycle as any load enable.
REQ-018 instr_valid while not ready SHALL be ignored, with no latching and no state change.

Reset
REQ-019 While res is 1 at a rising edge, the state SHALL become IDLE and the operand registers, latched instr and pc_target SHALL become 0.
REQ-020 In the cycle after a reset edge, every enable, save_byte, pc_load and done SHALL be 0 and instr_ready SHALL be 1.
REQ-021 Reset asserted during READ or WRITE SHALL abort the instruction, and no save_en or pc_load SHALL appear for it afterwards.
REQ-022 An instr_valid presented during reset SHALL NOT be accepted.

Structure
REQ-023 A shared package SHALL hold the mode codes, ALU op codes, condition codes, the FSM state encoding, and the slot-index constants (0 immediate/target, 1 and 2 operands, 3 result).
REQ-024 The ALU and condition evaluation SHALL be one combinational sub-module, alu8_cond, instantiated once inside the sequencer.

Verification
REQ-025 Bench scenario, IMM: instr=8'h2A accepted -> next cycle save_en=8'h01, save_byte=8'h2A, done=1; instr_ready=1 the following cycle.
REQ-026 Bench scenario, CALC ADD with slot1=8'hF0 and slot2=8'h20 (4 = ADD) -> load1_en=8'h02 and load2_en=8'h04 in N+1, then save_en=8'h08 and save_byte=8'h10 in N+2.
REQ-027 Bench scenario, COPY 5->7 (8'h AF) with slot5=8'h5C -> load1_en=8'h20, then save_en=8'h80 and save_byte=8'h5C.
REQ-028 Bench scenario, COND >0 with slot3=8'h80 -> pc_load=0; the same instruction with slot3=8'h01 and slot0=8'h40 -> pc_load=1 and pc_target=8'h40.
REQ-029 Bench scenario, res pulsed during READ of a CALC -> no save_en pulse afterwards, and instr_ready=1 one cycle after the reset edge.
REQ-030 Bench scenario, instr_valid held high continuously -> back-to-back acceptance every 2 (IMM) or 3 cycles, with the one-hot and no-overlap rules of REQ-017 never violated.
